// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared constants and parameter-legality helpers for the button
//            debouncer family (100 MHz board clock defaults).
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int DEFAULT_STABLE_CNT = 50_000;      // 0.5 ms at 100 MHz
    localparam int DEFAULT_HOLD_CYC   = 10_000_000;  // 100 ms at 100 MHz

    localparam int c_min_sync_stages  = 2;
    localparam int c_max_sync_stages  = 4;

    function automatic bit fits_width(input longint value, input int width);
        if (value < 0)
            return 1'b0;
        if (width >= 63)
            return 1'b1;
        return value <= ((longint'(1) <<< width) - 1);
    endfunction

    function automatic bit sync_stages_ok(input int stages);
        return (stages >= c_min_sync_stages) && (stages <= c_max_sync_stages);
    endfunction

    function automatic bit stable_cnt_ok(input longint stable_cnt, input int cnt_w);
        return (stable_cnt >= 1) && fits_width(stable_cnt, cnt_w);
    endfunction

    function automatic bit hold_cyc_ok(input longint hold_cyc, input int hold_w);
        return fits_width(hold_cyc, hold_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : debounce_chan
// Purpose  : One button channel: synchroniser, stable-count debounce filter,
//            press/release pulses and long-press detection.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
    parameter int HOLD_W      = 24,
    parameter int HOLD_CYC    = DEFAULT_HOLD_CYC,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pb,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_hold_pulse,
    output logic o_hold_level
);

    localparam logic             c_invert      = 1'(ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_pb ^ c_invert};
        cnt_d   = cnt_q;
        state_d = state_q;
        // Any sample that agrees with the current state restarts the count.
        if (w_sync == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_stable_last) begin
            state_d = w_sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d   = state_d & ~state_q;
        release_d = ~state_d & state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_state   = state_q;
    assign o_press   = press_q;
    assign o_release = release_q;

    if (HOLD_CYC == 0) begin : g_no_hold
        assign o_hold_pulse = 1'b0;
        assign o_hold_level = 1'b0;
    end else begin : g_hold
        localparam logic [HOLD_W-1:0] c_hold_max  = HOLD_W'(HOLD_CYC);
        localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYC - 1);

        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic              hold_pulse_q, hold_pulse_d;
        logic              hold_level_q, hold_level_d;

        // Counting starts the cycle after the press edge so the pulse lands
        // exactly HOLD_CYC cycles after press_pulse; a release on the boundary
        // clears the count first and so suppresses the pulse.
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            if (!state_d)
                hold_cnt_d = '0;
            else if (state_q && (hold_cnt_q != c_hold_max))
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            hold_pulse_d = (hold_cnt_q == c_hold_last) && (hold_cnt_d == c_hold_max);
            hold_level_d = state_d & (hold_level_q | hold_pulse_d);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_cnt_q   <= '0;
                hold_pulse_q <= 1'b0;
                hold_level_q <= 1'b0;
            end else begin
                hold_cnt_q   <= hold_cnt_d;
                hold_pulse_q <= hold_pulse_d;
                hold_level_q <= hold_level_d;
            end
        end

        assign o_hold_pulse = hold_pulse_q;
        assign o_hold_level = hold_level_q;
    end

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : N-channel push-button conditioner; one debounce_chan per pin.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
    parameter int HOLD_W      = 24,
    parameter int HOLD_CYC    = DEFAULT_HOLD_CYC,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] PB,
    output logic [N_CH-1:0] PB_state,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] hold_pulse,
    output logic [N_CH-1:0] hold_level
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("debounce_multi: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
    end
    if (!stable_cnt_ok(longint'(STABLE_CNT), CNT_W)) begin : g_bad_stable_cnt
        $error("debounce_multi: STABLE_CNT=%0d illegal for CNT_W=%0d", STABLE_CNT, CNT_W);
    end
    if (!hold_cyc_ok(longint'(HOLD_CYC), HOLD_W)) begin : g_bad_hold_cyc
        $error("debounce_multi: HOLD_CYC=%0d illegal for HOLD_W=%0d", HOLD_CYC, HOLD_W);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .STABLE_CNT  (STABLE_CNT),
            .HOLD_W      (HOLD_W),
            .HOLD_CYC    (HOLD_CYC),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_pb         (PB[i]),
            .o_state      (PB_state[i]),
            .o_press      (press_pulse[i]),
            .o_release    (release_pulse[i]),
            .o_hold_pulse (hold_pulse[i]),
            .o_hold_level (hold_level[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Directed, table-driven bench for debounce_multi (active-high and
//            active-low instances, STABLE_CNT=4, HOLD_CYC=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pb, pb_al;
    logic [3:0]  st, pr, rl, hp, hl;
    logic [3:0]  st_al, pr_al, rl_al, hp_al, hl_al;
    logic [19:0] w_out, w_out_al;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0]  pb;
        logic [19:0] exp;   // {state, press, release, hold_pulse, hold_level}
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(4), .SYNC_STAGES(2), .CNT_W(16), .STABLE_CNT(4),
        .HOLD_W(24), .HOLD_CYC(10), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PB(pb),
        .PB_state(st), .press_pulse(pr), .release_pulse(rl),
        .hold_pulse(hp), .hold_level(hl)
    );

    debounce_multi #(
        .N_CH(4), .SYNC_STAGES(2), .CNT_W(16), .STABLE_CNT(4),
        .HOLD_W(24), .HOLD_CYC(10), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .PB(pb_al),
        .PB_state(st_al), .press_pulse(pr_al), .release_pulse(rl_al),
        .hold_pulse(hp_al), .hold_level(hl_al)
    );

    assign w_out    = {st, pr, rl, hp, hl};
    assign w_out_al = {st_al, pr_al, rl_al, hp_al, hl_al};

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st/pr/rl/hp/hl=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     name, act[19:16], act[15:12], act[11:8], act[7:4], act[3:0],
                     exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] p, input logic [3:0] s,
                                input logic [3:0] pp, input logic [3:0] r);
        tbl.push_back('{pb: p, exp: {s, pp, r, 8'h00}});
    endfunction

    function automatic logic [19:0] ev(input int ch, input bit s, input bit p,
                                       input bit r, input bit h, input bit l);
        logic [3:0] m;
        m = 4'(1) << ch;
        return {s ? m : 4'h0, p ? m : 4'h0, r ? m : 4'h0, h ? m : 4'h0, l ? m : 4'h0};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] bpat;
        pb    = 4'h0;
        pb_al = 4'hF;
        rst_n = 1'b1;

        // Clean press/release on channel 0, then all four channels together.
        for (int r = 1; r <= 5; r++) add(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        for (int r = 1; r <= 2; r++) add(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        for (int r = 1; r <= 5; r++) add(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int r = 1; r <= 5; r++) add(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 4'b1111, 4'b1111, 4'b0000);
        add(4'b1111, 4'b1111, 4'b0000, 4'b0000);
        for (int r = 1; r <= 5; r++) add(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        add(4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Reset: asynchronous assertion, held three cycles.
        #2 rst_n = 1'b0;
        #1 check("reset_async", w_out, 20'h0);
        repeat (3) begin
            tick;
            check("reset_hold", w_out, 20'h0);
            check("reset_hold_al", w_out_al, 20'h0);
        end
        rst_n = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tick;
            check("idle", w_out, 20'h0);
            check("idle_al", w_out_al, 20'h0);
        end

        foreach (tbl[i]) begin
            pb = tbl[i].pb;
            tick;
            check($sformatf("tbl[%0d]", i), w_out, tbl[i].exp);
            check($sformatf("tbl_al[%0d]", i), w_out_al, 20'h0);
        end

        // Bounce: two 3-cycle highs split by a 1-cycle low never qualify.
        bpat = 12'b0000_0111_0111;
        for (int r = 0; r < 20; r++) begin
            pb = {2'b00, (r < 12) ? bpat[r] : 1'b0, 1'b0};
            tick;
            check($sformatf("bounce[%0d]", r), w_out, 20'h0);
        end

        // Long press on channel 2: 20 cycles high.
        for (int r = 1; r <= 30; r++) begin
            pb = (r <= 20) ? 4'b0100 : 4'b0000;
            tick;
            check($sformatf("long[%0d]", r), w_out,
                  ev(2, r >= 6 && r <= 25, r == 6, r == 26, r == 16, r >= 16 && r <= 25));
        end

        // Release lands exactly on the hold boundary: release wins, no hold.
        for (int r = 1; r <= 20; r++) begin
            pb = (r <= 10) ? 4'b0100 : 4'b0000;
            tick;
            check($sformatf("boundary[%0d]", r), w_out,
                  ev(2, r >= 6 && r <= 15, r == 6, r == 16, 1'b0, 1'b0));
        end

        // Reset in the middle of a held press on channel 3.
        pb = 4'b1000;
        for (int r = 1; r <= 8; r++) begin
            tick;
            check($sformatf("pre_rst[%0d]", r), w_out, ev(3, r >= 6, r == 6, 1'b0, 1'b0, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1 check("mid_rst_async", w_out, 20'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            tick;
            check($sformatf("post_rst[%0d]", r), w_out, ev(3, r >= 6, r == 6, 1'b0, 1'b0, 1'b0));
        end
        pb = 4'b0000;
        repeat (12) tick;

        // Active-low instance: channel 0 pressed by pulling the pin low.
        pb_al = 4'b1110;
        for (int r = 1; r <= 8; r++) begin
            tick;
            check($sformatf("al[%0d]", r), w_out_al, ev(0, r >= 6, r == 6, 1'b0, 1'b0, 1'b0));
        end
        pb_al = 4'b1111;
        repeat (10) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised N-channel push-button conditioner, the successor to the team's single-bit synchroniser. Each channel does three things:
- synchronises its raw pin through a configurable flop chain;
- debounces it with a stable-count filter;
- emits a debounced level, one-cycle press/release pulses and a long-press indication.
It sits between the board button pins and the parking-meter control FSM, which consumes only the pulses and levels.

Parameters:
N_CH, 4, number of independent button channels
SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4)
CNT_W, 16, width of the per-channel stability counter
STABLE_CNT, 50000, consecutive cycles a synchronised value must differ from the debounced state before the state flips (1..2^CNT_W-1)
HOLD_W, 24, width of the per-channel hold counter
HOLD_CYC, 10000000, cycles of continuous debounced press before a long-press is flagged; 0 disables long-press
ACTIVE_LOW, 0, 1 = pin is low when pressed (input inverted before synchroniser)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
PB  input  N_CH  raw, asynchronous button pins
PB_state  output  N_CH  debounced level per channel, 1 = pressed
press_pulse  output  N_CH  one-cycle pulse on debounced 0->1
release_pulse  output  N_CH  one-cycle pulse on debounced 1->0
hold_pulse  output  N_CH  one-cycle pulse when a press reaches HOLD_CYC cycles
hold_level  output  N_CH  high from hold_pulse until release

Behaviour:
- Reset:
  - rst_n low asynchronously clears all synchroniser flops, counters and outputs to 0 (PB_state=0 means "not pressed" after polarity correction).
  - Release is synchronous to clk.
- Polarity: the synchroniser input is PB[i] XOR ACTIVE_LOW.
- Synchroniser: SYNC_STAGES-flop chain per channel, no logic between stages. Its output s[i] lags the pin by SYNC_STAGES edges.
- Stability counter, per cycle:
  - if s==PB_state: cnt<=0;
  - else if cnt==STABLE_CNT-1: PB_state<=s, cnt<=0;
  - else cnt<=cnt+1.
- Debounce timing:
  - Net latency from a clean pin edge to the PB_state change is SYNC_STAGES+STABLE_CNT cycles.
  - A glitch shorter than STABLE_CNT cycles at s produces no output change, and cnt restarts from 0 on its return.
- Pulses:
  - press_pulse[i] is high in exactly the first cycle PB_state[i] reads 1.
  - release_pulse[i] is high in exactly the first cycle it reads 0.
  - Both are registered. They are mutually exclusive per channel and never high in back-to-back cycles, since the minimum spacing is STABLE_CNT.
- Hold counter:
  - Counts while PB_state=1 and saturates at HOLD_CYC; it is cleared to 0 whenever PB_state=0.
  - hold_pulse is high in the cycle the count transitions HOLD_CYC-1 -> HOLD_CYC; hold_level is set in the same cycle.
  - hold_level clears in the cycle release_pulse asserts.
  - With HOLD_CYC=0, hold_pulse and hold_level are tied 0.
- Release vs hold: a press released exactly on the hold boundary cycle gives priority to release. No hold_pulse is issued if PB_state is already 0 in that cycle.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Reset mid-count: all in-progress counts are discarded. After release, a held button is re-detected with full latency and produces a fresh press_pulse.
- Elaboration: out-of-range parameters (STABLE_CNT=0, STABLE_CNT>2^CNT_W-1, HOLD_CYC>2^HOLD_W-1, SYNC_STAGES<2) must stop elaboration with an error.

Decomposition:
- No typedefs needed. Parameter-legality checks and the DEFAULT_STABLE_CNT / DEFAULT_HOLD_CYC constants for the 100 MHz board clock go in the shared debounce_pkg.
- One sub-module, debounce_chan: single channel with synchroniser, stability counter, pulse and hold logic. It is instantiated N_CH times in a generate loop; the top holds no logic beyond the port slicing.

Test Plan (bench: N_CH=4, SYNC_STAGES=2, STABLE_CNT=4, HOLD_CYC=10, ACTIVE_LOW=0):
- Reset and clean press:
  - Stimulus: hold rst_n low 3 cycles, release, then at cycle 10 drive PB[0]=1 steadily.
  - Required response: all outputs 0 during reset. PB_state[0]=1 and press_pulse[0]=1 for one cycle at cycle 16 (2+4 latency); other channels stay 0.
- Bounce rejection:
  - Stimulus: PB[1] toggles 1,0,1,0 with 3-cycle high periods, then stays 0.
  - Required response: PB_state[1], press_pulse[1] and release_pulse[1] stay 0 throughout.
- Long press:
  - Stimulus: PB[2]=1 held 20 cycles, then 0.
  - Required response: hold_pulse[2] is one cycle, exactly 10 cycles after press_pulse[2]. hold_level[2] is high from that cycle until the release_pulse[2] cycle, 6 cycles after the pin drops.
- Simultaneous channels:
  - Stimulus: PB=4'b1111 in a single cycle.
  - Required response: press_pulse=4'b1111 in the same cycle; release after PB=0 gives release_pulse=4'b1111 together.
- Reset mid-operation:
  - Stimulus: PB[3]=1 held; assert rst_n low 2 cycles after press_pulse[3], release after 2 cycles.
  - Required response: outputs clear immediately (asynchronously). A second press_pulse[3] follows 6 cycles after rst_n rises.
- ACTIVE_LOW=1 variant:
  - Stimulus: PB idle at 4'b1111, then PB[0]=0.
  - Required response: no pulses out of reset; press_pulse[0] 6 cycles after PB[0] falls.
